// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a single slave.
interface axi_lite_cmd_master_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master: turns single-beat local commands into AXI4-Lite transactions,
// one outstanding at a time, with a saturating error count and a sticky stall timeout.
module axi_lite_cmd_master #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_TIMEOUT_CYCLES   = 256
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESET,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [7:0]                        err_count,
  output logic                              timeout,
  input  logic                              timeout_clr,
  axi_lite_cmd_master_if.master             m_axi
);

  localparam int unsigned DATA_W  = C_M_AXI_DATA_WIDTH;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned ERR_W   = 8;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(C_TIMEOUT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_MAX   = '1;
  localparam logic [ERR_W-1:0]   ERR_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t             state;
  logic [STALL_W-1:0] stall;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, busy, stall_hit;

  assign aw_hs     = m_axi.awvalid && m_axi.awready;
  assign w_hs      = m_axi.wvalid  && m_axi.wready;
  assign b_hs      = m_axi.bvalid  && m_axi.bready;
  assign ar_hs     = m_axi.arvalid && m_axi.arready;
  assign r_hs      = m_axi.rvalid  && m_axi.rready;
  assign any_hs    = aw_hs || w_hs || b_hs || ar_hs || r_hs;
  assign busy      = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
  assign stall_hit = busy && (stall == STALL_LIMIT);

  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state         <= IDLE;
      stall         <= '0;
      cmd_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      err_count     <= '0;
      timeout       <= 1'b0;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wstrb   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      // Stall counter restarts on every handshake; state entries below also clear it.
      if (busy) begin
        if (any_hs) begin
          stall <= '0;
        end else if (stall != STALL_MAX) begin
          stall <= stall + STALL_W'(1);
        end
      end

      // Set has priority over a coincident clear.
      if (stall_hit) begin
        timeout <= 1'b1;
      end else if (timeout_clr) begin
        timeout <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            stall     <= '0;
            if (cmd_write) begin
              m_axi.awaddr  <= cmd_addr;
              m_axi.wdata   <= cmd_wdata;
              m_axi.wstrb   <= cmd_wstrb;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= WR_REQ;
            end else begin
              m_axi.araddr  <= cmd_addr;
              m_axi.arvalid <= 1'b1;
              state         <= RD_REQ;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        WR_REQ: begin
          if (aw_hs) m_axi.awvalid <= 1'b0;
          if (w_hs)  m_axi.wvalid  <= 1'b0;
          if ((aw_hs || !m_axi.awvalid) && (w_hs || !m_axi.wvalid)) begin
            m_axi.bready <= 1'b1;
            stall        <= '0;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (b_hs) begin
            m_axi.bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_resp     <= m_axi.bresp;
            if ((m_axi.bresp != 2'b00) && (err_count != ERR_MAX)) begin
              err_count <= err_count + ERR_W'(1);
            end
            state <= RSP;
          end
        end

        RD_REQ: begin
          if (ar_hs) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            stall         <= '0;
            state         <= RD_RESP;
          end
        end

        RD_RESP: begin
          if (r_hs) begin
            m_axi.rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= 1'b0;
            rsp_rdata    <= DATA_W'(m_axi.rdata);
            rsp_resp     <= m_axi.rresp;
            if ((m_axi.rresp != 2'b00) && (err_count != ERR_MAX)) begin
              err_count <= err_count + ERR_W'(1);
            end
            state <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
